fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one synchronous FIFO write port between NUM_REQ requesters. It grants bursts of up to MAX_BURST words per requester and drives the FIFO's wr_en/data_in from registered outputs. It throttles on full/almostfull so that no arbiter-issued write ever overflows. It sits between producer blocks and the FIFO, alongside the existing FIFO interface signals.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/fifo_wr_arbiter_rr_arbiter.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned next_rr_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   idx_c
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                gnt_c[cand] = 1'b1;
                idx_c       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester granted-word counters when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    owner_id,
    output logic                          busy,
    output logic                          err_ovf,
    output logic [NUM_REQ*CNT_W-1:0]      word_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned BC_W  = $clog2(MAX_BURST + 1);

    arb_state_t               state, state_nxt;
    logic [IDX_W-1:0]         rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]         owner_nxt;
    logic [BC_W-1:0]          burst_cnt, burst_cnt_nxt;
    logic [NUM_REQ-1:0]       gnt_c;
    logic [NUM_REQ-1:0]       pick_gnt_c;
    logic [IDX_W-1:0]         pick_idx_c;
    logic                     can_wr_c;
    logic [FIFO_WIDTH-1:0]    data_sel_c;
    logic                     wr_en_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt_c  (pick_gnt_c),
        .idx_c  (pick_idx_c)
    );

    // The almostfull term accounts for the write already registered toward the FIFO.
    assign can_wr_c = !fifo_full && !(fifo_almostfull && fifo_wr_en);

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        owner_nxt     = owner_id;
        gnt_c         = '0;
        case (state)
            IDLE: begin
                if ((|req) && can_wr_c) begin
                    gnt_c         = pick_gnt_c;
                    owner_nxt     = pick_idx_c;
                    burst_cnt_nxt = BC_W'(1);
                    state_nxt     = BURST;
                end
            end
            BURST: begin
                if (req[owner_id] && can_wr_c && (burst_cnt < BC_W'(MAX_BURST))) begin
                    gnt_c[owner_id] = 1'b1;
                    burst_cnt_nxt   = burst_cnt + BC_W'(1);
                end
                if (!req[owner_id] || !can_wr_c || (burst_cnt_nxt == BC_W'(MAX_BURST))) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = IDX_W'(next_rr_idx(32'(owner_id), NUM_REQ));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Suppress grants while reset is held so no word is handed off and then dropped.
    assign gnt = rst_n ? gnt_c : '0;

    always_comb begin
        data_sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) data_sel_c = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            owner_id     <= '0;
            busy         <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            wr_en_q      <= 1'b0;
            err_ovf      <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            burst_cnt  <= burst_cnt_nxt;
            owner_id   <= owner_nxt;
            busy       <= (state_nxt == BURST);
            fifo_wr_en <= |gnt_c;
            if (|gnt_c) fifo_data_in <= data_sel_c;
            wr_en_q    <= fifo_wr_en;
            if (fifo_overflow && wr_en_q) err_ovf <= 1'b1;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Saturating per-requester granted-word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (gnt_c[i] && (word_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    word_cnt[i*CNT_W +: CNT_W] <= word_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`else
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (4 requesters, 16-bit words, bursts of 4).
module tb_fifo_wr_arbiter;

    typedef struct {
        logic [3:0]  req;
        logic        full;
        logic        af;
        logic        ovf;
        logic [3:0]  gnt;
        logic        wr;
        logic [15:0] data;
        logic        busy;
        logic [1:0]  own;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    logic [3:0]  gnt;
    logic        fifo_full, fifo_almostfull, fifo_overflow;
    logic        fifo_wr_en;
    logic [15:0] fifo_data_in;
    logic [1:0]  owner_id;
    logic        busy, err_ovf;
    logic [63:0] word_cnt;

    logic        tb_full = 1'b0, tb_af = 1'b0, tb_ovf = 1'b0;
    logic        model_en = 1'b0, rd = 1'b0, ovf_m = 1'b0;
    int          cnt = 0;
    int          n_chk = 0, n_fail = 0;
    vec_t        tbl[30];

    always #5 clk = ~clk;

    // Depth-8 FIFO occupancy model used for the throttle sequence.
    always @(posedge clk) begin
        if (!model_en) begin
            cnt   <= 0;
            ovf_m <= 1'b0;
        end else begin
            cnt   <= cnt + (fifo_wr_en ? 1 : 0) - (rd ? 1 : 0);
            ovf_m <= fifo_wr_en && !rd && (cnt == 8);
        end
    end

    assign fifo_full       = model_en ? (cnt == 8) : tb_full;
    assign fifo_almostfull = model_en ? (cnt == 7) : tb_af;
    assign fifo_overflow   = model_en ? ovf_m      : tb_ovf;

    fifo_wr_arbiter #(
        .FIFO_WIDTH (16),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_data        (req_data),
        .gnt             (gnt),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_overflow   (fifo_overflow),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .owner_id        (owner_id),
        .busy            (busy),
        .err_ovf         (err_ovf),
        .word_cnt        (word_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic use_model);
        rst_n    = 1'b0;
        req      = '0;
        rd       = 1'b0;
        tb_full  = 1'b0;
        tb_af    = 1'b0;
        tb_ovf   = 1'b0;
        model_en = use_model;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] rq, input logic f, input logic a, input logic o,
                                input logic [3:0] g, input logic w, input logic [15:0] d,
                                input logic b, input logic [1:0] ow, input logic e);
        vec_t v;
        v.req = rq; v.full = f; v.af = a; v.ovf = o;
        v.gnt = g; v.wr = w; v.data = d; v.busy = b; v.own = ow; v.err = e;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int writes;
        logic ovf_seen;
        logic [63:0] exp_cnt;

        //         req    f  af ovf  gnt   wr  data      busy own err
        tbl[0]  = mk(4'hF, 0, 0, 0, 4'h1, 0, 16'h0000, 0, 0, 0);
        tbl[1]  = mk(4'hF, 0, 0, 0, 4'h1, 1, 16'hA000, 1, 0, 0);
        tbl[2]  = mk(4'hF, 0, 0, 0, 4'h1, 1, 16'hA000, 1, 0, 0);
        tbl[3]  = mk(4'hF, 0, 0, 0, 4'h1, 1, 16'hA000, 1, 0, 0);
        tbl[4]  = mk(4'hF, 0, 0, 0, 4'h2, 1, 16'hA000, 0, 0, 0);
        tbl[5]  = mk(4'hF, 0, 0, 0, 4'h2, 1, 16'hA001, 1, 1, 0);
        tbl[6]  = mk(4'hF, 0, 0, 0, 4'h2, 1, 16'hA001, 1, 1, 0);
        tbl[7]  = mk(4'hF, 0, 0, 0, 4'h2, 1, 16'hA001, 1, 1, 0);
        tbl[8]  = mk(4'hF, 0, 0, 0, 4'h4, 1, 16'hA001, 0, 1, 0);
        tbl[9]  = mk(4'hF, 0, 0, 0, 4'h4, 1, 16'hA002, 1, 2, 0);
        tbl[10] = mk(4'hF, 0, 0, 0, 4'h4, 1, 16'hA002, 1, 2, 0);
        tbl[11] = mk(4'hF, 0, 0, 0, 4'h4, 1, 16'hA002, 1, 2, 0);
        tbl[12] = mk(4'hF, 0, 0, 0, 4'h8, 1, 16'hA002, 0, 2, 0);
        tbl[13] = mk(4'hF, 0, 0, 0, 4'h8, 1, 16'hA003, 1, 3, 0);
        tbl[14] = mk(4'hF, 0, 0, 0, 4'h8, 1, 16'hA003, 1, 3, 0);
        tbl[15] = mk(4'hF, 0, 0, 0, 4'h8, 1, 16'hA003, 1, 3, 0);
        tbl[16] = mk(4'hF, 0, 0, 0, 4'h1, 1, 16'hA003, 0, 3, 0);
        tbl[17] = mk(4'hF, 0, 0, 0, 4'h1, 1, 16'hA000, 1, 0, 0);
        tbl[18] = mk(4'hE, 0, 0, 0, 4'h0, 1, 16'hA000, 1, 0, 0);
        tbl[19] = mk(4'hE, 0, 0, 0, 4'h2, 0, 16'hA000, 0, 0, 0);
        tbl[20] = mk(4'h2, 0, 0, 0, 4'h2, 1, 16'hA001, 1, 1, 0);
        tbl[21] = mk(4'h2, 0, 1, 0, 4'h0, 1, 16'hA001, 1, 1, 0);
        tbl[22] = mk(4'h2, 1, 0, 0, 4'h0, 0, 16'hA001, 0, 1, 0);
        tbl[23] = mk(4'h2, 0, 0, 0, 4'h2, 0, 16'hA001, 0, 1, 0);
        tbl[24] = mk(4'h0, 0, 0, 0, 4'h0, 1, 16'hA001, 1, 1, 0);
        tbl[25] = mk(4'h0, 0, 0, 0, 4'h0, 0, 16'hA001, 0, 1, 0);
        tbl[26] = mk(4'h1, 0, 1, 1, 4'h1, 0, 16'hA001, 0, 1, 0);
        tbl[27] = mk(4'h1, 0, 1, 0, 4'h0, 1, 16'hA000, 1, 0, 0);
        tbl[28] = mk(4'h0, 0, 0, 1, 4'h0, 0, 16'hA000, 0, 0, 0);
        tbl[29] = mk(4'h0, 0, 0, 0, 4'h0, 0, 16'hA000, 0, 0, 1);

        // Reset values, with requests pending to show grants stay low in reset.
        req = 4'hF;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'h0);
        chk("rst_data", 64'(fifo_data_in), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_owner", 64'(owner_id), 64'h0);
        chk("rst_err", 64'(err_ovf), 64'h0);
        chk("rst_word_cnt", word_cnt, 64'h0);

        // Ten words from requester 2 for the statistics counters.
        do_reset(1'b0);
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            step();
            req = 4'b0100;
            #2;
            if (gnt == 4'b0100) n++;
        end
        step();
        req = '0;
        repeat (2) step();
        chk("stats_grants", 64'(n), 64'd10);
`ifdef FIFO_ARB_STATS_EN
        exp_cnt = {16'd0, 16'd10, 16'd0, 16'd0};
`else
        exp_cnt = 64'h0;
`endif
        chk("stats_word_cnt", word_cnt, exp_cnt);

        // Reset in the middle of a burst, then re-arbitration.
        do_reset(1'b0);
        step();
        req = 4'b0001;
        #2;
        chk("midrst_g1", 64'(gnt), 64'h1);
        step();
        #2;
        chk("midrst_g2", 64'(gnt), 64'h1);
        chk("midrst_busy_pre", 64'(busy), 64'h1);
        #1 rst_n = 1'b0;
        #2;
        chk("midrst_gnt", 64'(gnt), 64'h0);
        chk("midrst_wr_en", 64'(fifo_wr_en), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_regnt", 64'(gnt), 64'h1);
        step();
        #2;
        chk("midrst_wr_after", 64'(fifo_wr_en), 64'h1);
        chk("midrst_data_after", 64'(fifo_data_in), 64'hA000);

        // Cycle-by-cycle vector table.
        do_reset(1'b0);
        for (int i = 0; i < 30; i++) begin
            step();
            req     = tbl[i].req;
            tb_full = tbl[i].full;
            tb_af   = tbl[i].af;
            tb_ovf  = tbl[i].ovf;
            #2;
            chk($sformatf("row%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
            chk($sformatf("row%0d_wr_en", i), 64'(fifo_wr_en), 64'(tbl[i].wr));
            chk($sformatf("row%0d_data", i), 64'(fifo_data_in), 64'(tbl[i].data));
            chk($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
            chk($sformatf("row%0d_owner", i), 64'(owner_id), 64'(tbl[i].own));
            chk($sformatf("row%0d_err", i), 64'(err_ovf), 64'(tbl[i].err));
        end

        // Full throttle against a depth-8 FIFO model.
        do_reset(1'b1);
        writes   = 0;
        ovf_seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            req = 4'b0001;
            #2;
            if (fifo_wr_en) writes++;
            if (fifo_overflow) ovf_seen = 1'b1;
        end
        chk("thr_writes", 64'(writes), 64'd8);
        chk("thr_level", 64'(cnt), 64'd8);
        chk("thr_full", 64'(fifo_full), 64'h1);
        chk("thr_ovf", 64'(ovf_seen), 64'h0);
        chk("thr_err", 64'(err_ovf), 64'h0);
        step();
        rd = 1'b1;
        #2;
        if (fifo_wr_en) writes++;
        step();
        rd = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (fifo_wr_en) writes++;
            if (fifo_overflow) ovf_seen = 1'b1;
            step();
        end
        chk("thr_resume_writes", 64'(writes), 64'd9);
        chk("thr_resume_level", 64'(cnt), 64'd8);
        chk("thr_resume_ovf", 64'(ovf_seen), 64'h0);
        chk("thr_resume_err", 64'(err_ovf), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
